tick_gen: RTL
=============

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent tick channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 24: divisor and counter width in bits per channel.
REQ-003 SHALL have parameter DEF_DIV, default 6000: reset divisor for every channel; at 6 MHz this gives a 1 kHz tick.
REQ-004 SHALL have port clk, input, 1: system clock, 6 MHz from the on-chip HSOSC.
REQ-005 SHALL have port reset, input, 1: synchronous active-low reset.
REQ-006 SHALL have port load, input, 1: divisor load strobe.
REQ-007 SHALL have port load_mask, input, NUM_CH: channels updated on load.
REQ-008 SHALL have port div_in, input, NUM_CH*CNT_W: packed new divisors; channel c occupies bits [c*CNT_W +: CNT_W].
REQ-009 SHALL have port sync, input, 1: restart all channel counters together.
REQ-010 SHALL have port tick, output, NUM_CH: one-cycle enable pulse per channel.
REQ-011 SHALL have port sq, output, NUM_CH: 50%-duty square wave per channel.

Function
REQ-012 SHALL hold, per channel, a divisor register div_q[c] and a counter cnt[c], each CNT_W bits wide.
REQ-013 SHALL advance cnt[c] by 1 each cycle while div_q[c] != 0, and wrap it to 0 after cnt[c] == div_q[c]-1.
REQ-014 SHALL assert tick[c] exactly when cnt[c] == div_q[c]-1 and div_q[c] != 0, giving one pulse every div_q[c] cycles.
REQ-015 SHALL decode tick from registered state only, with no combinational path from any input to tick or sq.
REQ-016 SHALL treat div_q[c] == 0 as channel disabled: cnt[c] held at 0, tick[c] = 0, sq[c] frozen.
REQ-017 SHALL generate tick[c] high every cycle when div_q[c] == 1.
REQ-018 SHALL, on load high, set div_q[c] <= div_in slice and cnt[c] <= 0 for each channel with load_mask[c] = 1; unmasked channels are unaffected.
REQ-019 SHALL, after a load, produce the first new tick on the div_q-th cycle following the load edge.
REQ-020 SHALL, when load coincides with a terminal count, still show the current-cycle tick, then apply the load.
REQ-021 SHALL, on sync high, clear every cnt[c] to 0 and every sq[c] to 0 while leaving div_q unchanged.
REQ-022 SHALL, when sync and load occur in the same cycle, apply both: divisors load and all counters clear.
REQ-023 SHALL toggle sq[c] on each cycle where tick[c] = 1 (sq period = 2*div_q cycles).
REQ-024 SHALL keep channels fully independent apart from the shared sync.

Reset
REQ-025 SHALL, when reset = 0 at a clk rising edge, set div_q[c] = DEF_DIV, cnt[c] = 0, sq[c] = 0, and tick[c] = 0 for all c.
REQ-026 SHALL give reset priority over load and sync.
REQ-027 SHALL assert the first post-reset tick DEF_DIV cycles after reset deasserts.
REQ-028 SHALL discard partial counts when reset is asserted mid-period.

Configuration
REQ-029 SHALL implement the sq outputs and toggle registers only when macro TICK_GEN_SQ_EN is defined.
REQ-030 SHALL, without TICK_GEN_SQ_EN, drive sq to constant 0 and leave all tick behaviour unchanged.

Verification
REQ-031 SHALL cover this directed case: reset low 2 cycles, then release with NUM_CH=2, DEF_DIV=6000 -> both ticks first fire at cycle 6000, then every 6000 cycles.
REQ-032 SHALL cover this directed case: load=1, load_mask=2'b01, ch0 div=4 -> ch0 ticks at cycles 4, 8, 12 after load; ch1 cadence unchanged.
REQ-033 SHALL cover this directed case: ch1 div=0 loaded -> tick[1] stays 0 and sq[1] holds its value for 100 cycles; div=1 loaded -> tick[1] high every cycle.
REQ-034 SHALL cover this directed case: sync pulsed mid-period with div 3 and 5 -> both counters at 0 the next cycle; ticks at +3/+5; sq both 0.
REQ-035 SHALL cover this directed case: load coincident with a ch0 terminal count (div 4 -> 7) -> tick seen that cycle, next tick 7 cycles later.
REQ-036 SHALL cover this directed case: with TICK_GEN_SQ_EN defined, div=3 -> sq period 6 cycles, high 3; without the macro -> sq = 0 always.

Source files
------------

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Multi-channel programmable tick generator. Each channel divides clk by its
// own divisor and emits a one-cycle enable pulse (tick) once per period. With
// the optional square-wave feature, each channel also produces a 50%-duty
// square wave (sq) that toggles after every tick cycle.
//
// Optional feature macro: TICK_GEN_SQ_EN
//   defined   -> sq toggle registers are built
//   undefined -> sq is tied to 0; tick behaviour is identical
//
// Parameters
//   NUM_CH  : number of independent channels (1..8)
//   CNT_W   : divisor / counter width per channel
//   DEF_DIV : divisor every channel takes on reset
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-low reset
//   load      in   divisor load strobe
//   load_mask in   [NUM_CH]        channels updated by load
//   div_in    in   [NUM_CH*CNT_W]  new divisors, channel c at [c*CNT_W +: CNT_W]
//   sync      in   restart all counters (and square waves) together
//   tick      out  [NUM_CH]  one-cycle pulse per period, registered
//   sq        out  [NUM_CH]  square wave per channel, registered (or 0)
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 24,
  parameter int DEF_DIV = 6000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM_CH-1:0]       load_mask,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

  // True when a counter value is the last count of its period. A zero
  // divisor means the channel is disabled and never reaches terminal count.
  function automatic logic at_terminal(input logic [CNT_W-1:0] cnt_v,
                                       input logic [CNT_W-1:0] div_v);
    return (div_v != CNT_ZERO) && (cnt_v == (div_v - CNT_ONE));
  endfunction

  logic [CNT_W-1:0]  div_q_r   [NUM_CH];
  logic [CNT_W-1:0]  cnt_r     [NUM_CH];
  logic [CNT_W-1:0]  div_nxt_s [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt_s [NUM_CH];
  logic [NUM_CH-1:0] tick_r;
  logic [NUM_CH-1:0] tick_nxt_s;

  // Next divisor / counter per channel, and the tick that the next state
  // will decode to. Registering that decode keeps tick glitch-free while it
  // still reflects exactly the state the counter is in during that cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      div_nxt_s[c]  = div_q_r[c];
      cnt_nxt_s[c]  = CNT_ZERO;
      tick_nxt_s[c] = 1'b0;

      if (load && load_mask[c]) begin
        div_nxt_s[c] = div_in[c*CNT_W +: CNT_W];
      end else begin
        div_nxt_s[c] = div_q_r[c];
      end

      // Load and sync both restart the count; a disabled channel idles at 0.
      if ((load && load_mask[c]) || sync) begin
        cnt_nxt_s[c] = CNT_ZERO;
      end else if (div_q_r[c] == CNT_ZERO) begin
        cnt_nxt_s[c] = CNT_ZERO;
      end else if (at_terminal(cnt_r[c], div_q_r[c])) begin
        cnt_nxt_s[c] = CNT_ZERO;
      end else begin
        cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
      end

      tick_nxt_s[c] = at_terminal(cnt_nxt_s[c], div_nxt_s[c]);
    end
  end

  // Divisor, counter and tick state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        div_q_r[c] <= DEF_DIV_V;
        cnt_r[c]   <= CNT_ZERO;
      end
      tick_r <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        div_q_r[c] <= div_nxt_s[c];
        cnt_r[c]   <= cnt_nxt_s[c];
      end
      tick_r <= tick_nxt_s;
    end
  end

  assign tick = tick_r;

`ifdef TICK_GEN_SQ_EN
  logic [NUM_CH-1:0] sq_r;

  // Square-wave toggles: flip once after every tick cycle, so the period is
  // twice the divisor; sync realigns all waves low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sq_r <= {NUM_CH{1'b0}};
    end else if (sync) begin
      sq_r <= {NUM_CH{1'b0}};
    end else begin
      sq_r <= sq_r ^ tick_r;
    end
  end

  assign sq = sq_r;
`else
  assign sq = {NUM_CH{1'b0}};
`endif

endmodule
